rfphoenix_issue_scoreboard: RTL

Issue-stage hazard controller sitting between the instruction decoder and the register-file read/execute stage. Per thread it tracks which scalar/vector registers have a write outstanding, and counts those writes. It gates issue of each decoded instruction on RAW/WAW hazards, outstanding-write capacity and multicycle-unit availability. Writeback and flush events from later stages retire or discard the tracked state.

---
 rtl/rfphoenix_issue_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rfphoenix_issue_scoreboard.sv
// Issue-stage hazard scoreboard. Each thread tracks 128 pending-write bits
// (scalar + vector) and an outstanding-write count, and issue is gated on them.

module rfphoenix_issue_sb_thread #(
   parameter int MAXOUT = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         set_v,
   input  logic [6:0]   set_reg,
   input  logic         clr_v,
   input  logic [6:0]   clr_reg,
   input  logic         flush,
   output logic [127:0] pend,
   output logic [3:0]   cnt,
   output logic         wb_err
);
   logic clr_ok;

   // A retire is legal only if it matches a pending bit and there is a count to return.
   assign clr_ok = clr_v & pend[clr_reg] & (cnt != 4'd0);
   assign wb_err = clr_v & ~clr_ok;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pend <= '0;
         cnt  <= '0;
      end else begin
         if (clr_ok) pend[clr_reg] <= 1'b0;
         // The set is written last so it overrides a same-cycle clear of the same register.
         if (set_v)  pend[set_reg] <= 1'b1;
         cnt <= cnt + {3'b0, set_v} - {3'b0, clr_ok};
      end
   end
endmodule

module rfphoenix_issue_scoreboard #(
   parameter int NTHREADS = 4,
   parameter int MAXOUT   = 7,
   localparam int TW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dec_v,
   input  logic [TW-1:0]       dec_tid,
   input  logic [6:0]          dec_Ra,
   input  logic [6:0]          dec_Rb,
   input  logic [6:0]          dec_Rc,
   input  logic [6:0]          dec_Rt,
   input  logic [6:0]          dec_Rm,
   input  logic                dec_hasRa,
   input  logic                dec_hasRb,
   input  logic                dec_hasRc,
   input  logic                dec_hasRm,
   input  logic                dec_hasRt,
   input  logic                dec_wr,
   input  logic                dec_multicycle,
   output logic                issue,
   output logic                stall,
   input  logic                wb_v,
   input  logic [TW-1:0]       wb_tid,
   input  logic [6:0]          wb_Rt,
   input  logic                mc_done,
   input  logic                flush_v,
   input  logic [TW-1:0]       flush_tid,
   output logic [NTHREADS-1:0] busy_o,
   output logic                mc_busy,
   output logic                err
);
   localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

   logic [NTHREADS-1:0][127:0] pend;
   logic [NTHREADS-1:0][3:0]   cnt;
   logic [NTHREADS-1:0]        wb_err;
   logic [127:0]               tpend;
   logic                       hazard;
   logic                       rt_trk;
   logic                       cap_full;
   logic                       dec_flushed;

   assign tpend  = pend[dec_tid];
   assign rt_trk = (dec_Rt != 7'd0);

   // Scalar r0 is never tracked, so every lookup on it is masked out.
   always_comb begin
      hazard = 1'b0;
      if (dec_hasRa && dec_Ra != 7'd0 && tpend[dec_Ra]) hazard = 1'b1;
      if (dec_hasRb && dec_Rb != 7'd0 && tpend[dec_Rb]) hazard = 1'b1;
      if (dec_hasRc && dec_Rc != 7'd0 && tpend[dec_Rc]) hazard = 1'b1;
      if (dec_hasRm && dec_Rm != 7'd0 && tpend[dec_Rm]) hazard = 1'b1;
      if (dec_hasRt && dec_wr && rt_trk && tpend[dec_Rt]) hazard = 1'b1;
   end

   assign cap_full    = dec_wr & rt_trk & (cnt[dec_tid] == MAXOUT_C);
   assign dec_flushed = flush_v & (flush_tid == dec_tid);
   assign issue       = dec_v & ~hazard & ~cap_full & ~(dec_multicycle & mc_busy) & ~dec_flushed;
   assign stall       = dec_v & ~issue;

   for (genvar t = 0; t < NTHREADS; t++) begin : g_thr
      logic flush_t;
      assign flush_t   = flush_v & (flush_tid == TW'(t));
      assign busy_o[t] = (cnt[t] != 4'd0);

      // A retire to a thread being flushed is dropped silently.
      rfphoenix_issue_sb_thread #(.MAXOUT(MAXOUT)) u_thr (
         .clk     (clk),
         .rst     (rst),
         .set_v   (issue & dec_wr & rt_trk & (dec_tid == TW'(t))),
         .set_reg (dec_Rt),
         .clr_v   (wb_v & (wb_Rt != 7'd0) & (wb_tid == TW'(t)) & ~flush_t),
         .clr_reg (wb_Rt),
         .flush   (flush_t),
         .pend    (pend[t]),
         .cnt     (cnt[t]),
         .wb_err  (wb_err[t])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc_busy <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (issue && dec_multicycle) mc_busy <= 1'b1;
         else if (mc_done)            mc_busy <= 1'b0;
         if ((|wb_err) || (mc_done && !mc_busy)) err <= 1'b1;
      end
   end
endmodule
